serial_word_tx: RTL and testbench
=================================

// Module: serial_word_tx
// PURPOSE
//   Parallel-to-serial word transmitter; drives the bit-serial stream consumed by
//   the serial two's complementer (invert). Accepts a WIDTH-bit word on a
//   valid/ready handshake and emits it LSB first, one bit per t_clk. Outputs the
//   per-bit word-start marker (ser_r) on bit 0, and holds ser_r high while idle.
//   Sits between the parallel datapath and the serial arithmetic chain.
// PARAMETERS
//   WIDTH     8   bits per word (>=2)
//   IDLE_GAP  0   minimum idle cycles forced between consecutive words (0 = back-to-back)
// PORTS
//   t_clk      in   1      clock, all logic on rising edge
//   r_n        in   1      synchronous active-low reset
//   in_data    in   WIDTH  parallel word, bit 0 sent first
//   in_valid   in   1      in_data valid; must hold data stable until accepted
//   in_ready   out  1      transmitter can accept a word this cycle
//   ser_i      out  1      serial data bit (to invert i)
//   ser_r      out  1      word-start marker (to invert r): 1 on bit 0 and while idle
//   ser_v      out  1      ser_i carries a valid data bit
//   word_done  out  1      one-cycle pulse coincident with the last bit (bit WIDTH-1)
//   busy       out  1      word in flight (equals ser_v)
// BEHAVIOUR
//   Reset (r_n=0 at an edge): state IDLE, gap counter 0, shift reg 0; registered outputs
//     ser_i=0, ser_r=1, ser_v=0, word_done=0, busy=0. in_ready forced 0 while r_n=0.
//     Reset mid-word aborts it: no word_done, remaining bits discarded.
//   Accept: in_valid & in_ready at an edge latches in_data into the shift register.
//   States: IDLE, SHIFT, GAP.
//     IDLE: ser_v=0, ser_i=0, ser_r=1. in_ready=1. Accept -> SHIFT, bit count 0.
//     SHIFT: on cycle n (n=0..WIDTH-1) after accept: ser_i=word[n], ser_v=1,
//       ser_r=(n==0), word_done=(n==WIDTH-1). Shift right each edge, count +1.
//       Last bit, IDLE_GAP=0: in_ready=1; accept -> SHIFT n=0 next cycle (no bubble);
//       else -> IDLE.
//       Last bit, IDLE_GAP>0: in_ready=0 -> GAP with counter IDLE_GAP.
//     GAP: idle outputs (ser_v=0, ser_i=0, ser_r=1), in_ready=0; counter decrements
//       each edge. -> IDLE when it reaches 1, so exactly IDLE_GAP idle cycles precede
//       the earliest next bit 0 ... plus 1 handshake cycle in IDLE.
//   Latency: word accepted at edge k -> bit 0 valid in cycle following edge k;
//     bit n in the cycle following edge k+n. Serial outputs are registered, no comb path
//     from in_data/in_valid to ser_*.
//   in_ready is combinational from state/count only (not from in_valid).
//   in_valid while not ready: ignored; in_data changes are not sampled.
//   Bit counter width clog2(WIDTH); wraps only via explicit reload, never by overflow.
//   Idle outputs i=0,r=1 hold the downstream complementer in its word-reset condition.
// TESTING (WIDTH=8 unless stated)
//   1 Reset 2 cycles, send 0x16 -> ser_i 0,1,1,0,1,0,0,0 on 8 consecutive cycles; ser_r=1
//     only on the first; ser_v=1 for all 8; word_done only on the 8th; then idle values.
//   2 IDLE_GAP=0, in_valid held with 0xA5 then 0xFF -> 16 contiguous bits
//     1,0,1,0,0,1,0,1,1,1,1,1,1,1,1,1; ser_r on bits 0 and 8; in_ready high on the 8th bit.
//   3 IDLE_GAP=2, two words 0x01,0x80 -> 2 GAP cycles + 1 IDLE cycle between them
//     (ser_v=0,ser_r=1,ser_i=0); in_ready=0 throughout GAP.
//   4 Reset asserted after bit 3 of 0xFF -> next cycle idle values, no word_done pulse;
//     following word 0x01 sends 1,0,0,0,0,0,0,0 cleanly.
//   5 in_valid with 0x33 raised during SHIFT of 0x0F, data changed to 0x55 before
//     ready -> second word sent as 0x55; 0x33 never appears on ser_i.
//   6 Chain ser_i/ser_r/t_clk into invert, send 0x16 -> y stream 0,1,0,1,0,1,1,1 (0xEA),
//     offset by invert's fixed latency; back-to-back 0x01 -> 1,1,1,1,1,1,1,1 (0xFF).

Source files
------------

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it LSB first,
// one bit per clock, with a word-start marker (ser_r) on bit 0.
// While nothing is in flight the outputs sit at i=0, r=1. That idle pattern holds
// the downstream serial complementer in its word-reset condition.
//
// Handshake: a word is transferred on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on state and bit count (never on in_valid).
// The producer must hold in_data stable while in_valid is high and unaccepted.
// in_data is not sampled on edges where in_ready is low.
module serial_word_tx #(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_i,
    output logic             ser_r,
    output logic             ser_v,
    output logic             word_done,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gap;
    logic             r_ser_i;
    logic             r_ser_r;
    logic             r_ser_v;
    logic             r_done;

    state_t           w_state;
    logic [WIDTH-1:0] w_shift;
    logic [CW-1:0]    w_cnt;
    logic [GW-1:0]    w_gap;
    logic             w_ser_i;
    logic             w_ser_r;
    logic             w_ser_v;
    logic             w_done;
    logic             w_ready;
    logic             w_accept;

    // Next-state and next-output logic; r_cnt is the index of the bit currently on ser_i.
    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_cnt    = r_cnt;
        w_gap    = r_gap;
        w_ser_i  = 1'b0;
        w_ser_r  = 1'b1;
        w_ser_v  = 1'b0;
        w_done   = 1'b0;
        w_ready  = 1'b0;

        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_SHIFT: if (r_cnt == LAST_BIT) w_ready = (IDLE_GAP == 0);
            default: w_ready = 1'b0;
        endcase

        w_accept = in_valid & w_ready;

        case (r_state)
            S_SHIFT: begin
                if (r_cnt != LAST_BIT) begin
                    w_ser_i = r_shift[0];
                    w_ser_r = 1'b0;
                    w_ser_v = 1'b1;
                    w_shift = r_shift >> 1;
                    w_cnt   = r_cnt + CW'(1);
                    w_done  = ((r_cnt + CW'(1)) == LAST_BIT);
                end else if (IDLE_GAP > 0) begin
                    w_state = S_GAP;
                    w_gap   = GAP_LOAD;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_GAP: begin
                // The gap counter counts down to 1 so exactly IDLE_GAP cycles are spent here.
                if (r_gap == GW'(1)) begin
                    w_state = S_IDLE;
                end else begin
                    w_gap = r_gap - GW'(1);
                end
            end
            default: ;
        endcase

        // An accepted word puts bit 0 on the wire at the very next edge.
        if (w_accept) begin
            w_state = S_SHIFT;
            w_cnt   = '0;
            w_shift = in_data >> 1;
            w_ser_i = in_data[0];
            w_ser_r = 1'b1;
            w_ser_v = 1'b1;
            w_done  = 1'b0;
        end
    end

    // State and registered serial outputs; reset aborts any word in flight.
    always_ff @(posedge t_clk) begin
        if (!r_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ser_i <= 1'b0;
            r_ser_r <= 1'b1;
            r_ser_v <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_ser_i <= w_ser_i;
            r_ser_r <= w_ser_r;
            r_ser_v <= w_ser_v;
            r_done  <= w_done;
        end
    end

    assign in_ready    = w_ready & r_n;
    assign ser_i       = r_ser_i;
    assign ser_r       = r_ser_r;
    assign ser_v       = r_ser_v;
    assign word_done   = r_done;
    assign busy        = r_ser_v;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx: two instances (IDLE_GAP=0 and IDLE_GAP=2) checked
// every cycle against a word-level timeline model, plus literal stream checks.
module tb_serial_word_tx;

    localparam int W = 8;

    logic       t_clk;
    logic       r_n;
    logic [7:0] in_data_w  [2];
    logic       in_valid_w [2];
    logic       in_ready_w [2];
    logic       ser_i_w    [2];
    logic       ser_r_w    [2];
    logic       ser_v_w    [2];
    logic       done_w     [2];
    logic       busy_w     [2];
    logic [1:0] dbg_w      [2];

    int n_checks = 0;
    int n_pass   = 0;

    // per-cycle log entries: {in_ready, ser_v, word_done, ser_r, ser_i}
    logic [4:0] log0[$];
    logic [4:0] log1[$];

    // ---------------- clock / reset ----------------
    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs + model + compare ----------------
    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int G = (g == 0) ? 0 : 2;

        // expected per-cycle output of the word in flight: {done, r, i}
        logic [2:0] exp_q[$];
        int  earliest = 0;
        int  edge_no  = 0;
        bit  model_on = 1'b0;

        serial_word_tx #(.WIDTH(W), .IDLE_GAP(G)) dut (
            .t_clk       (t_clk),
            .r_n         (r_n),
            .in_data     (in_data_w[g]),
            .in_valid    (in_valid_w[g]),
            .in_ready    (in_ready_w[g]),
            .ser_i       (ser_i_w[g]),
            .ser_r       (ser_r_w[g]),
            .ser_v       (ser_v_w[g]),
            .word_done   (done_w[g]),
            .busy        (busy_w[g]),
            .o_dbg_state (dbg_w[g])
        );

        // Model: an accepted word occupies the next W cycles; the next accept is
        // allowed W edges later, plus G gap cycles and one idle cycle when G>0.
        always @(posedge t_clk) begin
            edge_no = edge_no + 1;
            if (!r_n) begin
                exp_q.delete();
                earliest = edge_no + 1;
                model_on = 1'b1;
            end else if (model_on) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid_w[g] && edge_no >= earliest) begin
                    for (int n = 0; n < W; n++)
                        exp_q.push_back({(n == W - 1), (n == 0), in_data_w[g][n]});
                    earliest = edge_no + W + ((G == 0) ? 0 : G + 1);
                end
            end
        end

        // Compare all outputs against the model in the middle of every cycle.
        always @(negedge t_clk) begin : cmp
            logic [2:0] e;
            logic       ev;
            logic       er;
            logic [5:0] act;
            logic [5:0] expv;
            if (model_on) begin
                ev   = (exp_q.size() > 0);
                e    = ev ? exp_q[0] : 3'b010;
                er   = r_n && (edge_no + 1 >= earliest);
                expv = {er, ev, ev, e};
                act  = {in_ready_w[g], ser_v_w[g], busy_w[g], done_w[g], ser_r_w[g], ser_i_w[g]};
                n_checks = n_checks + 1;
                if (act === expv) n_pass = n_pass + 1;
                else $display("FAIL cycle_u%0d edge=%0d got={rdy,v,busy,done,r,i}=%b expected=%b",
                              g, edge_no, act, expv);
            end
        end
    end

    // Record outputs of both instances for literal stream checks.
    always @(negedge t_clk) begin
        log0.push_back({in_ready_w[0], ser_v_w[0], done_w[0], ser_r_w[0], ser_i_w[0]});
        log1.push_back({in_ready_w[1], ser_v_w[1], done_w[1], ser_r_w[1], ser_i_w[1]});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        r_n = 1'b0;
        repeat (n) tick();
        r_n = 1'b1;
    endtask

    task automatic send(input int u, input logic [7:0] d);
        bit rdy;
        bit ok;
        ok = 1'b0;
        in_data_w[u]  = d;
        in_valid_w[u] = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge t_clk);
            rdy = in_ready_w[u];
            tick();
            if (rdy) ok = 1'b1;
        end
        in_valid_w[u] = 1'b0;
        if (!ok) begin
            n_checks = n_checks + 1;
            $display("FAIL send_timeout_u%0d got=no_accept expected=accept of %h", u, d);
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    // Reduces a log to the valid-bit stream (LSB = first bit) and gap facts;
    // comp is the stream after a serial two's complement reset by ser_r.
    task automatic analyze(input int u, output int nv, output logic [31:0] bits,
                           output logic [31:0] rpat, output logic [31:0] dpat,
                           output logic [31:0] rdy, output logic [31:0] comp,
                           output int gap_len, output logic [31:0] gap_rdy);
        logic [4:0] e;
        bit  seen;
        int  n, first, last, ng;
        nv = 0; bits = '0; rpat = '0; dpat = '0; rdy = '0; comp = '0;
        gap_rdy = '0; first = -1; last = -1; seen = 1'b0; ng = 0;
        n = (u == 0) ? log0.size() : log1.size();
        for (int k = 0; k < n; k++) begin
            e = (u == 0) ? log0[k] : log1[k];
            if (e[3]) begin
                if (first < 0) first = k;
                last = k;
                if (e[1]) seen = 1'b0;
                if (nv < 32) begin
                    bits[nv] = e[0]; rpat[nv] = e[1]; dpat[nv] = e[2];
                    rdy[nv] = e[4]; comp[nv] = e[0] ^ seen;
                end
                seen = seen | e[0];
                nv = nv + 1;
            end
        end
        gap_len = (first < 0) ? 0 : (last - first + 1 - nv);
        for (int k = first + 1; k < last && first >= 0; k++) begin
            e = (u == 0) ? log0[k] : log1[k];
            if (!e[3] && ng < 32) begin
                gap_rdy[ng] = e[4];
                ng = ng + 1;
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int nv, gl;
        logic [31:0] bits, rpat, dpat, rdy, comp, grdy;
        r_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_data_w[u]  = '0;
            in_valid_w[u] = 1'b0;
        end
        @(posedge t_clk); #1;
        do_reset(2);

        // single word 0x16
        clear_logs();
        send(0, 8'h16);
        repeat (12) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t1_nbits", nv, 8);
        check("t1_bits", bits, 32'h0000_0016);
        check("t1_ser_r", rpat, 32'h0000_0001);
        check("t1_word_done", dpat, 32'h0000_0080);
        check("t1_contiguous", gl, 0);
        check("t1_complement", comp, 32'h0000_00EA);

        // back-to-back 0xA5, 0xFF with IDLE_GAP=0
        clear_logs();
        send(0, 8'hA5);
        send(0, 8'hFF);
        repeat (12) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t2_nbits", nv, 16);
        check("t2_bits", bits, 32'h0000_FFA5);
        check("t2_ser_r", rpat, 32'h0000_0101);
        check("t2_word_done", dpat, 32'h0000_8080);
        check("t2_ready_last_bit", rdy, 32'h0000_8080);
        check("t2_contiguous", gl, 0);

        // back-to-back 0x01, 0x01 complemented per word
        clear_logs();
        send(0, 8'h01);
        send(0, 8'h01);
        repeat (12) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t6_nbits", nv, 16);
        check("t6_complement", comp, 32'h0000_FFFF);

        // IDLE_GAP=2: 0x01 then 0x80
        clear_logs();
        send(1, 8'h01);
        send(1, 8'h80);
        repeat (12) tick();
        analyze(1, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t3_nbits", nv, 16);
        check("t3_bits", bits, 32'h0000_8001);
        check("t3_ser_r", rpat, 32'h0000_0101);
        check("t3_gap_cycles", gl, 3);
        check("t3_gap_ready", grdy, 32'h0000_0004);
        check("t3_ready_in_word", rdy, 32'h0000_0000);

        // reset after bit 3 of 0xFF
        clear_logs();
        send(0, 8'hFF);
        repeat (3) tick();
        r_n = 1'b0;
        tick();
        r_n = 1'b1;
        repeat (3) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t4_nbits_aborted", nv, 4);
        check("t4_bits_aborted", bits, 32'h0000_000F);
        check("t4_no_word_done", dpat, 32'h0000_0000);
        clear_logs();
        send(0, 8'h01);
        repeat (12) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t4_next_nbits", nv, 8);
        check("t4_next_bits", bits, 32'h0000_0001);
        check("t4_next_word_done", dpat, 32'h0000_0080);

        // data changes while not ready: 0x33 replaced by 0x55
        clear_logs();
        send(0, 8'h0F);
        in_data_w[0]  = 8'h33;
        in_valid_w[0] = 1'b1;
        repeat (3) tick();
        send(0, 8'h55);
        repeat (12) tick();
        analyze(0, nv, bits, rpat, dpat, rdy, comp, gl, grdy);
        check("t5_nbits", nv, 16);
        check("t5_bits", bits, 32'h0000_550F);
        check("t5_contiguous", gl, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
